serial_tx: RTL and testbench



---
 rtl/serial_tx.sv | 149 ++++++++++++++
 tb/tb_serial_tx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Bit-serial transmitter: start bit, DATA_W data bits LSB-first, optional even parity, stop bit.
// Defining SERIAL_TX_PARITY_EN inserts the parity bit between the data bits and the stop bit.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_reg, state_next;
    logic [CW-1:0]     cyc_reg, cyc_next;
    logic [BW-1:0]     bit_reg, bit_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              tx_reg, tx_next;
    logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_reg, parity_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cyc_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cyc_reg    <= cyc_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
`ifdef SERIAL_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    assign bit_end = (cyc_reg == CYC_LAST);

    always_comb begin
        state_next  = state_reg;
        cyc_next    = cyc_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
`ifdef SERIAL_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (valid) begin
                    state_next  = START;
                    shift_next  = data_in;
                    cyc_next    = '0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_next = ^data_in;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    cyc_next   = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_next   = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BIT_LAST) begin
                        bit_next = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + BW'(1);
                    end
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cyc_next   = '0;
                    state_next = STOP;
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cyc_next   = '0;
                    state_next = IDLE;
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cyc_next   = '0;
            end
        endcase
    end

    // tx is registered from the next state so the line level lines up with state_reg and busy.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    assign tx    = tx_reg;
    assign ready = (state_reg == IDLE);
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one DUT at CLKS_PER_BIT=4 and one at CLKS_PER_BIT=1.
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 10 + PAR;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid, valid1;
    logic [7:0] data_in, data1;
    logic       ready, tx, busy;
    logic       ready1, tx1, busy1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(ready), .tx(tx), .busy(busy)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bit k: 0 start, 1..8 data LSB-first, optional parity, then stop.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (PAR == 1 && k == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " tx"}, tx, 1);
        check({tag, " ready"}, ready, 1);
        check({tag, " busy"}, busy, 0);
    endtask

    // Called at the first negedge after the accept edge; returns at the negedge after the frame.
    task automatic check_frame(input logic [7:0] d, input bit keep_valid, input logic [7:0] end_data);
        for (int i = 0; i < NB * 4; i++) begin
            check($sformatf("tx %02h c%0d", d, i), tx, exp_bit(d, i / 4));
            check($sformatf("busy %02h c%0d", d, i), busy, 1);
            check($sformatf("ready %02h c%0d", d, i), ready, 0);
            if (!keep_valid && i == 0) valid = 1'b0;
            if (keep_valid && i == 5) data_in = 8'h00;
            if (keep_valid && i == NB * 4 - 1) data_in = end_data;
            @(negedge clk);
        end
        $display("frame %02h: %0d cycles checked", d, NB * 4);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; data_in = 8'h00; valid1 = 1'b0; data1 = 8'h00;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset ready1", ready1, 1);
        check("reset tx1", tx1, 1);

        // Reset and valid together: nothing accepted.
        valid = 1'b1; data_in = 8'h55;
        @(negedge clk);
        check_idle("rst+valid");
        valid = 1'b0; rst = 1'b0;
        $display("rst with valid: no accept");

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle c%0d", i));
        end
        $display("idle 10 cycles");

        data_in = 8'hA5; valid = 1'b1;
        @(negedge clk);
        check_frame(8'hA5, 1'b0, 8'h00);
        check_idle("after A5");

        data_in = 8'h07; valid = 1'b1;
        @(negedge clk);
        check_frame(8'h07, 1'b0, 8'h00);
        check_idle("after 07");

        // Back-to-back with valid held: exactly one idle cycle between frames.
        data_in = 8'h3C; valid = 1'b1;
        @(negedge clk);
        check_frame(8'h3C, 1'b1, 8'hFF);
        check_idle("gap");
        @(negedge clk);
        check_frame(8'hFF, 1'b0, 8'h00);
        check_idle("after FF");

        // Abort 13 cycles into a frame; valid held high through reset.
        data_in = 8'hA5; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            check($sformatf("pre-rst tx c%0d", i), tx, exp_bit(8'hA5, i / 4));
            @(negedge clk);
        end
        rst = 1'b1; valid = 1'b1; data_in = 8'h81;
        @(negedge clk);
        check_idle("rst mid");
        $display("frame A5 aborted by reset");
        rst = 1'b0;
        @(negedge clk);
        check_frame(8'h81, 1'b0, 8'h00);
        check_idle("after 81");

        data1 = 8'h01; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        for (int i = 0; i < NB; i++) begin
            check($sformatf("tx1 c%0d", i), tx1, exp_bit(8'h01, i));
            check($sformatf("busy1 c%0d", i), busy1, 1);
            @(negedge clk);
        end
        check("after1 ready1", ready1, 1);
        check("after1 busy1", busy1, 0);
        check("after1 tx1", tx1, 1);
        $display("frame 01 at 1 clk/bit: %0d cycles checked", NB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
